// File: rtl/branch_unit.sv
// Branch/jump resolution for the execute stage: drives the external comparator,
// picks the target and hands a redirect + flush to fetch. Optional: BRANCH_STATS_EN.
module branch_unit #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = {XLEN{1'b0}}
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_br_valid,
    output logic            o_br_ready,
    input  logic [1:0]      i_br_op,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_cmp_eq,
    output logic [1:0]      o_cmp_mode,
    output logic [XLEN-1:0] o_cmp_a,
    output logic [XLEN-1:0] o_cmp_b,
    input  logic [XLEN-1:0] i_cmp_result,
    output logic            o_redir_valid,
    input  logic            i_redir_ready,
    output logic [XLEN-1:0] o_redir_pc,
    output logic            o_flush,
    output logic [XLEN-1:0] o_link,
    output logic            o_done,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     o_stat_br,
    output logic [31:0]     o_stat_taken,
`endif
    output logic            o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EVAL  = 2'b01,
        S_REDIR = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] SIGN_FLIP = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_op;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_f3_valid;
    logic            w_taken;
    logic            w_misal;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_unused_cmp;

    assign w_unused_cmp = ^i_cmp_result[XLEN-1:1];
    assign w_link       = r_pc + {{(XLEN-3){1'b0}}, 3'd4};

    // Comparator drive; unsigned compares bias both operands so the signed comparator orders them correctly
    always_comb begin
        o_cmp_eq   = 1'b0;
        o_cmp_mode = 2'b00;
        o_cmp_a    = {XLEN{1'b0}};
        o_cmp_b    = {XLEN{1'b0}};
        w_f3_valid = 1'b0;
        if (r_state == S_EVAL && r_op == 2'b00) begin
            case (r_funct3)
                3'b000: begin o_cmp_eq = 1'b1; o_cmp_mode = 2'b10; o_cmp_a = r_rs1; o_cmp_b = r_rs2; w_f3_valid = 1'b1; end
                3'b001: begin o_cmp_mode = 2'b10; o_cmp_a = r_rs1; o_cmp_b = r_rs2; w_f3_valid = 1'b1; end
                3'b100: begin o_cmp_mode = 2'b00; o_cmp_a = r_rs1; o_cmp_b = r_rs2; w_f3_valid = 1'b1; end
                3'b101: begin o_cmp_mode = 2'b01; o_cmp_a = r_rs1; o_cmp_b = r_rs2; w_f3_valid = 1'b1; end
                3'b110: begin o_cmp_mode = 2'b00; o_cmp_a = r_rs1 ^ SIGN_FLIP; o_cmp_b = r_rs2 ^ SIGN_FLIP; w_f3_valid = 1'b1; end
                3'b111: begin o_cmp_mode = 2'b01; o_cmp_a = r_rs1 ^ SIGN_FLIP; o_cmp_b = r_rs2 ^ SIGN_FLIP; w_f3_valid = 1'b1; end
                default: begin o_cmp_mode = 2'b00; w_f3_valid = 1'b0; end
            endcase
        end else begin
            w_f3_valid = 1'b0;
        end
    end

    // Taken decision and target address
    always_comb begin
        w_taken  = 1'b0;
        w_target = r_pc + r_imm;
        case (r_op)
            2'b00:   w_taken = w_f3_valid & i_cmp_result[0];
            2'b01:   w_taken = 1'b1;
            2'b10: begin
                w_taken  = 1'b1;
                w_target = (r_rs1 + r_imm) & LSB_CLEAR;
            end
            default: w_taken = 1'b0;
        endcase
        w_misal = w_taken & (w_target[1:0] != 2'b00);
    end

    // Handshake and retirement outputs
    always_comb begin
        o_br_ready    = (r_state == S_IDLE);
        o_redir_valid = (r_state == S_REDIR);
        o_redir_pc    = r_redir_pc;
        o_flush       = (r_state == S_REDIR) & i_redir_ready;
        o_misalign    = (r_state == S_EVAL) & w_misal;
        o_done        = ((r_state == S_EVAL) & (~w_taken | w_misal)) | o_flush;
        if (o_done) begin
            o_link = w_link;
        end else begin
            o_link = {XLEN{1'b0}};
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_br_valid) begin
                    w_next_state = S_EVAL;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EVAL: begin
                if (w_taken && !w_misal) begin
                    w_next_state = S_REDIR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REDIR: begin
                if (i_redir_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_REDIR;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, request capture and redirect target registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_funct3   <= 3'b000;
            r_pc       <= {XLEN{1'b0}};
            r_rs1      <= {XLEN{1'b0}};
            r_rs2      <= {XLEN{1'b0}};
            r_imm      <= {XLEN{1'b0}};
            r_redir_pc <= RST_PC;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && i_br_valid) begin
                r_op     <= i_br_op;
                r_funct3 <= i_funct3;
                r_pc     <= i_pc;
                r_rs1    <= i_rs1;
                r_rs2    <= i_rs2;
                r_imm    <= i_imm;
            end
            if (r_state == S_EVAL && w_next_state == S_REDIR) begin
                r_redir_pc <= w_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_taken;

    // Retirement counters, free-running with natural wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_br    <= 32'd0;
            r_stat_taken <= 32'd0;
        end else begin
            if (o_done && r_op == 2'b00) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (o_flush) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end
        end
    end

    assign o_stat_br    = r_stat_br;
    assign o_stat_taken = r_stat_taken;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes expected retirements, a
// negedge monitor pops and compares on every o_done.
module tb_branch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_br_valid;
    logic        o_br_ready;
    logic [1:0]  i_br_op;
    logic [2:0]  i_funct3;
    logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
    logic        o_cmp_eq;
    logic [1:0]  o_cmp_mode;
    logic [31:0] o_cmp_a, o_cmp_b;
    logic [31:0] i_cmp_result;
    logic        o_redir_valid;
    logic        i_redir_ready;
    logic [31:0] o_redir_pc;
    logic        o_flush;
    logic [31:0] o_link;
    logic        o_done;
    logic        o_misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] o_stat_br, o_stat_taken;
`endif

    typedef struct packed {
        logic        flush;
        logic        misal;
        logic        chk_link;
        logic [31:0] link;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   flush_cnt = 0;
    int   fc0;

    always #5 i_clk = ~i_clk;

    branch_unit #(.XLEN(32), .RST_PC(32'h0)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_br_valid(i_br_valid), .o_br_ready(o_br_ready),
        .i_br_op(i_br_op), .i_funct3(i_funct3),
        .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_cmp_eq(o_cmp_eq), .o_cmp_mode(o_cmp_mode),
        .o_cmp_a(o_cmp_a), .o_cmp_b(o_cmp_b), .i_cmp_result(i_cmp_result),
        .o_redir_valid(o_redir_valid), .i_redir_ready(i_redir_ready),
        .o_redir_pc(o_redir_pc), .o_flush(o_flush), .o_link(o_link),
        .o_done(o_done),
`ifdef BRANCH_STATS_EN
        .o_stat_br(o_stat_br), .o_stat_taken(o_stat_taken),
`endif
        .o_misalign(o_misalign)
    );

    // Comparator model: mode 10 equality (eq selects == or !=), 00 signed <, 01 signed >=
    always_comb begin
        i_cmp_result = 32'd0;
        case (o_cmp_mode)
            2'b10:   i_cmp_result[0] = o_cmp_eq ? (o_cmp_a == o_cmp_b) : (o_cmp_a != o_cmp_b);
            2'b00:   i_cmp_result[0] = ($signed(o_cmp_a) <  $signed(o_cmp_b));
            2'b01:   i_cmp_result[0] = ($signed(o_cmp_a) >= $signed(o_cmp_b));
            default: i_cmp_result[0] = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic fl, input logic mis, input logic cl,
                                input logic [31:0] lk, input logic [31:0] pc);
        exp_t e;
        e.flush = fl; e.misal = mis; e.chk_link = cl; e.link = lk; e.pc = pc;
        return e;
    endfunction

    // Monitor: every retirement must match the oldest expected response
    always @(negedge i_clk) begin
        exp_t e;
        if (o_flush) flush_cnt++;
        if (o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("flush", {31'd0, o_flush}, {31'd0, e.flush});
                chk("misalign", {31'd0, o_misalign}, {31'd0, e.misal});
                if (e.chk_link) chk("link", o_link, e.link);
                if (e.flush) chk("redir_pc", o_redir_pc, e.pc);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input exp_t e);
        int n = 0;
        while (!o_br_ready && n < 50) begin @(posedge i_clk); #1; n++; end
        chk("accept_ready", {31'd0, o_br_ready}, 32'd1);
        sb.push_back(e);
        i_br_valid = 1'b1; i_br_op = op; i_funct3 = f3;
        i_pc = pc; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        @(posedge i_clk); #1;
        i_br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_br_ready && n < 50) begin @(posedge i_clk); #1; n++; end
        chk("return_idle", {31'd0, o_br_ready}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_br_ready"}, {31'd0, o_br_ready}, 32'd1);
        chk({tag, "_redir_valid"}, {31'd0, o_redir_valid}, 32'd0);
        chk({tag, "_redir_pc"}, o_redir_pc, 32'h0);
        chk({tag, "_flush_done"}, {30'd0, o_flush, o_done}, 32'd0);
        chk({tag, "_link"}, o_link, 32'd0);
        chk({tag, "_cmp_a"}, o_cmp_a, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_br_valid = 1'b0; i_br_op = 2'b00; i_funct3 = 3'b000;
        i_pc = 32'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_imm = 32'd0; i_redir_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_state("reset");
        i_rst = 1'b0;

        // 1: BEQ taken, immediate handshake
        send(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, mk(1'b1, 1'b0, 1'b0, 32'h104, 32'h120));
        chk("beq_cmp_eq", {31'd0, o_cmp_eq}, 32'd1);
        chk("beq_cmp_mode", {30'd0, o_cmp_mode}, 32'd2);
        @(posedge i_clk); #1;
        chk("beq_redir_valid", {31'd0, o_redir_valid}, 32'd1);
        chk("beq_redir_pc", o_redir_pc, 32'h120);
        @(posedge i_clk); #1;
        chk("beq_idle_2cyc", {31'd0, o_br_ready}, 32'd1);

        // 2: BLTU not taken (unsigned), BLT taken (signed)
        send(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        chk("bltu_cmp_a", o_cmp_a, 32'h7FFF_FFFF);
        chk("bltu_cmp_b", o_cmp_b, 32'h8000_0001);
        chk("bltu_cmp_mode", {30'd0, o_cmp_mode}, 32'd0);
        chk("bltu_no_redir", {31'd0, o_redir_valid}, 32'd0);
        @(posedge i_clk); #1;
        chk("bltu_idle_1cyc", {31'd0, o_br_ready}, 32'd1);
        chk("bltu_no_redir2", {31'd0, o_redir_valid}, 32'd0);
        send(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h210));
        chk("blt_cmp_a", o_cmp_a, 32'hFFFF_FFFF);
        wait_idle();

        // 3: JALR aligned, JALR misaligned, JAL, undefined funct3, reserved op
        send(2'b10, 3'b000, 32'h40, 32'h203, 32'd0, 32'd1, mk(1'b1, 1'b0, 1'b1, 32'h44, 32'h204));
        wait_idle();
        send(2'b10, 3'b000, 32'h40, 32'h206, 32'd0, 32'd0, mk(1'b0, 1'b1, 1'b1, 32'h44, 32'h0));
        chk("jalr_misal_pulse", {31'd0, o_misalign}, 32'd1);
        @(posedge i_clk); #1;
        chk("jalr_misal_no_redir", {31'd0, o_redir_valid}, 32'd0);
        chk("jalr_misal_idle", {31'd0, o_br_ready}, 32'd1);
        chk("misal_one_cycle", {31'd0, o_misalign}, 32'd0);
        send(2'b01, 3'b000, 32'h300, 32'd0, 32'd0, 32'h40, mk(1'b1, 1'b0, 1'b1, 32'h304, 32'h340));
        wait_idle();
        send(2'b00, 3'b010, 32'h400, 32'd9, 32'd9, 32'h40, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        @(posedge i_clk); #1;
        chk("undef_f3_no_redir", {31'd0, o_redir_valid}, 32'd0);
        send(2'b11, 3'b000, 32'h400, 32'd9, 32'd9, 32'h40, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        @(posedge i_clk); #1;
        chk("op11_no_redir", {31'd0, o_redir_valid}, 32'd0);

        // 4: BGE taken with fetch stalled 3 cycles; busy requests ignored
        i_redir_ready = 1'b0;
        fc0 = flush_cnt;
        send(2'b00, 3'b101, 32'h80, 32'd10, 32'd3, 32'hFFFF_FFF8, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h78));
        i_br_valid = 1'b1; i_br_op = 2'b01; i_pc = 32'h900; i_imm = 32'h4;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("stall_valid", {31'd0, o_redir_valid}, 32'd1);
            chk("stall_pc", o_redir_pc, 32'h78);
            chk("stall_br_ready", {31'd0, o_br_ready}, 32'd0);
            chk("stall_no_flush", {31'd0, o_flush}, 32'd0);
        end
        i_br_valid = 1'b0;
        i_redir_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("stall_flush_once", flush_cnt, fc0 + 1);
        chk("stall_back_idle", {31'd0, o_br_ready}, 32'd1);
        @(posedge i_clk); #1;
        chk("stall_extra_ignored", {31'd0, o_redir_valid}, 32'd0);

        // 5: reset while redirect pending
        i_redir_ready = 1'b0;
        send(2'b00, 3'b000, 32'h700, 32'd3, 32'd3, 32'h40, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h740));
        @(posedge i_clk); #1;
        chk("pre_rst_redir", {31'd0, o_redir_valid}, 32'd1);
        i_rst = 1'b1;
        sb.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_redir_ready = 1'b1;
        chk_reset_state("midrst");
        send(2'b00, 3'b001, 32'h10, 32'd1, 32'd2, 32'h100, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h110));
        wait_idle();

        // 6: statistics sequence from a fresh reset
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        send(2'b00, 3'b000, 32'h500, 32'd7, 32'd7, 32'h8, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h508));
        wait_idle();
        send(2'b00, 3'b001, 32'h510, 32'd7, 32'd7, 32'h8, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        wait_idle();
        send(2'b00, 3'b111, 32'h520, 32'hFFFF_FFFF, 32'd1, 32'h4, mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h524));
        chk("bgeu_cmp_a", o_cmp_a, 32'h7FFF_FFFF);
        chk("bgeu_cmp_mode", {30'd0, o_cmp_mode}, 32'd1);
        wait_idle();
        send(2'b01, 3'b000, 32'h600, 32'd0, 32'd0, 32'h10, mk(1'b1, 1'b0, 1'b1, 32'h604, 32'h610));
        wait_idle();
`ifdef BRANCH_STATS_EN
        chk("stat_br", o_stat_br, 32'd3);
        chk("stat_taken", o_stat_taken, 32'd3);
`endif

        @(posedge i_clk); #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
